fifo_rr_arbiter: RTL and testbench

- Round-robin packet arbiter that drains NUM_QUEUES fallthrough small FIFOs (one per input port) into a single registered output stream.
- Each FIFO word is {ctrl, data}. The arbiter never splits a packet: once a queue is granted, it reads that queue until end-of-packet, then moves on.
- Sits between the per-port input FIFOs and the downstream datapath stage. The downstream stage's nearly_full, inverted, drives out_rdy.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_priority_select.sv | 23 ++
 rtl/fifo_rr_arbiter.sv | 83 ++++++++
 tb/tb_fifo_rr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type, counter width and {ctrl,data} word layout helpers
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;
  localparam int PKT_CNT_WIDTH = 32;
  localparam int DATA_LSB = 0;
  function automatic int ctrl_lsb(input int data_width);
    return data_width;
  endfunction
  function automatic int word_width(input int data_width, input int ctrl_width);
    return data_width + ctrl_width;
  endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational rotate-priority picker, first req at or after ptr wins
// Ports: req (per-queue request), ptr (highest-priority index), gnt (winner index), gnt_valid (any req)
module rr_priority_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          gnt_valid
);
  int j;
  // Walk from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt = '0;
    j = 0;
    gnt_valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[PW'(j)]) gnt = PW'(j);
    end
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin packet arbiter draining fallthrough input FIFOs into one registered stream
// Ports: clk; reset (async, active-low); in_fifo_dout/in_fifo_empty/in_fifo_rd_en per-queue FIFO head,
//        flag and pop; out_data/out_ctrl/out_wr registered output word; out_rdy downstream accept;
//        pkt_count per-queue EOP counters, live only when FIFO_RR_ARBITER_PKT_COUNT_EN is defined.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_QUEUES*(CTRL_WIDTH+DATA_WIDTH)-1:0] in_fifo_dout,
  input  logic [NUM_QUEUES-1:0]                       in_fifo_empty,
  output logic [NUM_QUEUES-1:0]                       in_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]                       out_data,
  output logic [CTRL_WIDTH-1:0]                       out_ctrl,
  output logic                                        out_wr,
  input  logic                                        out_rdy,
  output logic [NUM_QUEUES*PKT_CNT_WIDTH-1:0]         pkt_count
);
  localparam int W  = word_width(DATA_WIDTH, CTRL_WIDTH);
  localparam int CL = ctrl_lsb(DATA_WIDTH);
  localparam int PW = $clog2(NUM_QUEUES);
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, grant, pick;
  logic pick_valid, rd, eop;
  logic [W-1:0] words [NUM_QUEUES];
  logic [W-1:0] head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_word
    assign words[g] = in_fifo_dout[g*W +: W];
  end
  assign head = words[grant];
  assign head_ctrl = head[CL +: CTRL_WIDTH];
  rr_priority_select #(.N(NUM_QUEUES), .PW(PW)) u_sel (
    .req      (~in_fifo_empty),
    .ptr      (rr_ptr),
    .gnt      (pick),
    .gnt_valid(pick_valid)
  );
  // Reads only ever target the latched grant; IDLE never reads, giving one bubble per packet.
  always_comb begin
    rd = (state != IDLE) && !in_fifo_empty[grant] && out_rdy;
    eop = rd && (state == PKT) && (head_ctrl != '0);
    in_fifo_rd_en = rd ? NUM_QUEUES'(1) << grant : '0;
    state_nxt = (state == IDLE) ? (pick_valid ? HDR : IDLE) :
                (state == HDR)  ? ((rd && head_ctrl == '0) ? PKT : HDR) :
                                  (eop ? IDLE : PKT);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) grant <= pick;
      if (eop) rr_ptr <= (grant == PW'(NUM_QUEUES - 1)) ? '0 : grant + 1'b1;
      out_wr <= rd;
      if (rd) begin
        out_data <= head[DATA_LSB +: DATA_WIDTH];
        out_ctrl <= head_ctrl;
      end
    end
  end
`ifdef FIFO_RR_ARBITER_PKT_COUNT_EN
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
    logic [PKT_CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else if (eop && grant == PW'(g)) cnt <= cnt + 1'b1;
    end
    assign pkt_count[g*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = cnt;
  end
`else
  assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: table-driven and scoreboarded bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;
  localparam int NQ = 4, DW = 64, CW = 8, W = 72;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NQ*W-1:0] in_fifo_dout;
  logic [NQ-1:0] in_fifo_empty, in_fifo_rd_en;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic out_wr;
  logic out_rdy = 1'b1;
  logic [NQ*32-1:0] pkt_count;

  fifo_rr_arbiter #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_fifo_dout(in_fifo_dout), .in_fifo_empty(in_fifo_empty),
    .in_fifo_rd_en(in_fifo_rd_en), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int n;
    int order [4];
  } vec_t;
  vec_t tbl [8];

  logic [W-1:0] fq [NQ][$];
  logic [W-1:0] pend [NQ][$];
  logic [W-1:0] exp_q [$];
  int total = 0, bad = 0, wid = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      in_fifo_empty[i] = fq[i].size() == 0;
      in_fifo_dout[i*W +: W] = fq[i].size() == 0 ? '0 : fq[i][0];
    end
  endtask

  task automatic put(input int q, input logic [CW-1:0] c, input bit to_exp);
    logic [W-1:0] w;
    w = {c, 16'hA5A5, 16'(q), 32'(wid)};
    wid++;
    fq[q].push_back(w);
    if (to_exp) exp_q.push_back(w);
    else pend[q].push_back(w);
  endtask

  task automatic load_pkt(input int q, input int nhdr, input int npay, input bit eop, input bit to_exp);
    for (int h = 0; h < nhdr; h++) put(q, h == 0 ? 8'hFF : 8'h10, to_exp);
    for (int p = 0; p < npay; p++) put(q, 8'h00, to_exp);
    if (eop) put(q, 8'h01, to_exp);
  endtask

  task automatic release_q(input int q);
    while (pend[q].size() != 0) exp_q.push_back(pend[q].pop_front());
  endtask

  task automatic set_vec(input int t, input logic [3:0] m, input int n, input int o0, input int o1,
                         input int o2, input int o3);
    tbl[t].mask = m;
    tbl[t].n = n;
    tbl[t].order[0] = o0;
    tbl[t].order[1] = o1;
    tbl[t].order[2] = o2;
    tbl[t].order[3] = o3;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    int left;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
    chk({nm, "_idle"}, in_fifo_rd_en, 0);
    left = 0;
    for (int i = 0; i < NQ; i++) left += fq[i].size();
    chk({nm, "_fifos_empty"}, left, 0);
  endtask

  // FIFO model: pops what the DUT strobed in the previous cycle, then presents the new heads.
  initial begin
    logic [NQ-1:0] rs;
    drive();
    forever begin
      @(negedge clk);
      rs = in_fifo_rd_en;
      @(posedge clk);
      #2;
      if (reset)
        for (int i = 0; i < NQ; i++)
          if (rs[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      drive();
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic [W-1:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_wr", out_wr, 0);
        last = '0;
      end else if (out_wr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_wr act=%0h want=none", {out_ctrl, out_data});
        end else chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
        last = {out_ctrl, out_data};
      end else chk("out_hold", {out_ctrl, out_data}, last);
      chk("rd_onehot", $countones(in_fifo_rd_en) <= 1, 1);
      if (!out_rdy) chk("rd_stall", in_fifo_rd_en, 0);
      for (int i = 0; i < NQ; i++)
        if (in_fifo_rd_en[i]) chk("rd_nonempty", fq[i].size() != 0, 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int trail;
    set_vec(0, 4'b1111, 4, 0, 1, 2, 3);
    set_vec(1, 4'b1010, 2, 1, 3, 0, 0);
    set_vec(2, 4'b0010, 1, 1, 0, 0, 0);
    set_vec(3, 4'b1001, 2, 3, 0, 0, 0);
    set_vec(4, 4'b0101, 2, 2, 0, 0, 0);
    set_vec(5, 4'b0100, 1, 2, 0, 0, 0);
    set_vec(6, 4'b0111, 3, 0, 1, 2, 0);
    set_vec(7, 4'b1111, 4, 3, 0, 1, 2);
    repeat (2) @(negedge clk);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_rd_en", in_fifo_rd_en, 0);
    chk("rst_pkt_count", pkt_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      for (int q = 0; q < NQ; q++)
        if (tbl[t].mask[q]) load_pkt(q, 1 + (q % 2), 1 + q, 1'b1, 1'b0);
      for (int k = 0; k < tbl[t].n; k++) release_q(tbl[t].order[k]);
      wait_drain("rr_table");
    end

    @(posedge clk);
    #1 load_pkt(0, 1, 3, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("single_rd", in_fifo_rd_en, (k >= 1 && k <= 5) ? 4'b0001 : 4'b0000);
      chk("single_wr", out_wr, k >= 2);
    end
    wait_drain("single");

    @(posedge clk);
    #1 load_pkt(1, 1, 6, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #3 out_rdy = 1'b0;
    trail = 0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_rd", in_fifo_rd_en, 0);
      trail += int'(out_wr);
    end
    chk("stall_trail", trail <= 1, 1);
    @(posedge clk);
    #3 out_rdy = 1'b1;
    wait_drain("backpressure");

    @(posedge clk);
    #1;
    load_pkt(0, 1, 2, 1'b0, 1'b1);
    load_pkt(1, 1, 2, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("starve_rd1", in_fifo_rd_en[1], 0);
    end
    chk("starve_q1_kept", fq[1].size(), 4);
    @(posedge clk);
    #1;
    put(0, 8'h00, 1'b1);
    put(0, 8'h01, 1'b1);
    release_q(1);
    wait_drain("refill");

    @(posedge clk);
    #1 load_pkt(2, 1, 10, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_wr", out_wr, 0);
    chk("midrst_rd", in_fifo_rd_en, 0);
    chk("midrst_cnt", pkt_count, 0);
    for (int q = 0; q < NQ; q++) begin
      fq[q].delete();
      pend[q].delete();
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) load_pkt(2, 1, 2, 1'b1, 1'b1);
    wait_drain("count");
`ifdef FIFO_RR_ARBITER_PKT_COUNT_EN
    chk("cnt_q2", pkt_count[2*32 +: 32], 3);
`else
    chk("cnt_q2", pkt_count[2*32 +: 32], 0);
`endif
    chk("cnt_other", {pkt_count[0 +: 64], pkt_count[96 +: 32]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
